data_sram_like_slave: RTL and testbench

Responder end of the data SRAM-like interface driven by the pre-MEM stage. It accepts load/store requests with an `addr_ok` handshake, holds up to QUEUE_DEPTH outstanding requests, and returns in-order `data_ok`/`rdata` responses after a fixed latency from a word-addressed backing RAM. It sits outside the CPU core as the simulation/FPGA data-memory model, or behind a cache bypass path.

---
 rtl/data_sram_like_slave.sv | 196 +++++++++++++++++++
 tb/tb_data_sram_like_slave.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_like_slave.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_like_slave
//  Description : Responder end of the data SRAM-like interface. Accepts
//                load/store requests with an addr_ok handshake, keeps up to
//                QUEUE_DEPTH requests outstanding in a circular queue, and
//                returns in-order data_ok/rdata responses no earlier than
//                LATENCY cycles after acceptance, from a word-addressed RAM.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    AW          log2 of backing RAM depth in 32-bit words
//    LATENCY     minimum cycles from acceptance to response (1..15)
//    QUEUE_DEPTH maximum outstanding requests (power of two, 2..8)
//  Ports
//    clk           clock, rising edge
//    reset         asynchronous active-high reset
//    data_req      request valid
//    data_wr       1 = store, 0 = load
//    data_size     transfer size (not used by this responder)
//    data_wstrb    byte write enables for stores
//    data_addr     byte address, word index = data_addr[AW+1:2]
//    data_wdata    store data
//    data_addr_ok  request accepted this cycle (combinational)
//    data_rdata    load data, valid while data_data_ok is high
//    data_data_ok  one-cycle response pulse for the oldest request
// ============================================================================
module data_sram_like_slave #(
    parameter int AW          = 12,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok
);

    localparam int              C_PW       = $clog2(QUEUE_DEPTH);
    // Countdown holds the number of cycles left until the response cycle as
    // seen from the cycle after acceptance, so it reads 0 in the response
    // cycle itself. The head is popped one edge earlier, when it reads <= 1.
    localparam logic [3:0]      C_CNT_INIT = 4'(LATENCY - 1);
    localparam logic [C_PW-1:0] C_PTR_ONE  = C_PW'(1);
    localparam logic [C_PW:0]   C_OCC_ONE  = (C_PW + 1)'(1);
    localparam logic [C_PW+1:0] C_DEPTH    = (C_PW + 2)'(QUEUE_DEPTH);
    // With a latency of one the response edge is the acceptance edge, so a
    // request arriving at an empty queue must be answered without queueing.
    localparam bit              C_BYPASS   = (LATENCY == 1);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic            r_q_wr    [QUEUE_DEPTH];
    logic [3:0]      r_q_wstrb [QUEUE_DEPTH];
    logic [AW-1:0]   r_q_idx   [QUEUE_DEPTH];
    logic [31:0]     r_q_wdata [QUEUE_DEPTH];
    logic [3:0]      r_q_cnt   [QUEUE_DEPTH];

    logic [C_PW-1:0] r_head;
    logic [C_PW-1:0] r_tail;
    logic [C_PW:0]   r_occ;

    logic [31:0]     r_mem [2**AW];

    // ------------------------------------------------------------------
    // Handshake and pop selection
    // ------------------------------------------------------------------
    logic [C_PW+1:0] w_outstanding;
    logic            w_accept;
    logic            w_ring_empty;
    logic            w_head_ready;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [AW-1:0]   w_req_idx;
    logic            w_pop_wr;
    logic [3:0]      w_pop_wstrb;
    logic [AW-1:0]   w_pop_idx;
    logic [31:0]     w_pop_wdata;
    logic            w_unused;

    assign w_req_idx = data_addr[AW+1:2];

    // The entry whose data_ok is showing this cycle has already left the
    // ring but still counts as outstanding until the end of the cycle.
    assign w_outstanding = {1'b0, r_occ} + {{(C_PW + 1){1'b0}}, data_data_ok};

    assign w_accept     = !reset && data_req && (w_outstanding < C_DEPTH);
    assign data_addr_ok = w_accept;

    assign w_ring_empty = (r_occ == '0);
    assign w_head_ready = !w_ring_empty && (r_q_cnt[r_head] <= 4'd1);
    assign w_bypass     = C_BYPASS && w_ring_empty && w_accept;
    assign w_push       = w_accept && !w_bypass;
    assign w_pop        = w_head_ready || w_bypass;

    always_comb begin
        w_pop_wr    = r_q_wr[r_head];
        w_pop_wstrb = r_q_wstrb[r_head];
        w_pop_idx   = r_q_idx[r_head];
        w_pop_wdata = r_q_wdata[r_head];
        if (w_bypass) begin
            w_pop_wr    = data_wr;
            w_pop_wstrb = data_wstrb;
            w_pop_idx   = w_req_idx;
            w_pop_wdata = data_wdata;
        end
    end

    // Size and the address bits outside the word index do not affect the
    // response; the RAM aliases modulo its depth.
    assign w_unused = ^{data_size, data_addr[31:AW+2], data_addr[1:0]};

    // ------------------------------------------------------------------
    // Queue payload and countdowns (contents only meaningful while valid)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (r_q_cnt[i] != 4'd0) begin
                r_q_cnt[i] <= r_q_cnt[i] - 4'd1;
            end
        end
        if (w_push) begin
            r_q_wr[r_tail]    <= data_wr;
            r_q_wstrb[r_tail] <= data_wstrb;
            r_q_idx[r_tail]   <= w_req_idx;
            r_q_wdata[r_tail] <= data_wdata;
            r_q_cnt[r_tail]   <= C_CNT_INIT;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + C_PTR_ONE;
            end
            if (w_head_ready) begin
                r_head <= r_head + C_PTR_ONE;
            end
            case ({w_push, w_head_ready})
                2'b10:   r_occ <= r_occ + C_OCC_ONE;
                2'b01:   r_occ <= r_occ - C_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered response. Earlier stores were written on earlier edges,
    // so the RAM read here already reflects them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_data_ok <= 1'b0;
            data_rdata   <= 32'h0;
        end else begin
            data_data_ok <= w_pop;
            if (w_pop && !w_pop_wr) begin
                data_rdata <= r_mem[w_pop_idx];
            end else begin
                data_rdata <= 32'h0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Backing RAM: stores land on the pop edge, lane by lane. Not cleared
    // by reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && w_pop && w_pop_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_pop_wstrb[b]) begin
                    r_mem[w_pop_idx][8*b +: 8] <= w_pop_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_like_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_sram_like_slave
//  Description : Scoreboard bench for data_sram_like_slave. Three instances
//                with different LATENCY/QUEUE_DEPTH. The driver predicts the
//                acceptance cycle, response cycle and read data from a
//                word-level memory model and pushes them into a per-instance
//                queue; a negedge monitor pops and compares on data_data_ok.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_sram_like_slave;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic        wr    [3];
    logic [1:0]  size  [3];
    logic [3:0]  strb  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        aok   [3];
    logic [31:0] rdata [3];
    logic        dok   [3];

    always #5 clk = ~clk;

    data_sram_like_slave #(.AW(AW), .LATENCY(2), .QUEUE_DEPTH(4)) u_dut0 (
        .clk(clk), .reset(rst), .data_req(req[0]), .data_wr(wr[0]), .data_size(size[0]),
        .data_wstrb(strb[0]), .data_addr(addr[0]), .data_wdata(wdata[0]),
        .data_addr_ok(aok[0]), .data_rdata(rdata[0]), .data_data_ok(dok[0]));

    data_sram_like_slave #(.AW(AW), .LATENCY(1), .QUEUE_DEPTH(2)) u_dut1 (
        .clk(clk), .reset(rst), .data_req(req[1]), .data_wr(wr[1]), .data_size(size[1]),
        .data_wstrb(strb[1]), .data_addr(addr[1]), .data_wdata(wdata[1]),
        .data_addr_ok(aok[1]), .data_rdata(rdata[1]), .data_data_ok(dok[1]));

    data_sram_like_slave #(.AW(AW), .LATENCY(8), .QUEUE_DEPTH(4)) u_dut2 (
        .clk(clk), .reset(rst), .data_req(req[2]), .data_wr(wr[2]), .data_size(size[2]),
        .data_wstrb(strb[2]), .data_addr(addr[2]), .data_wdata(wdata[2]),
        .data_addr_ok(aok[2]), .data_rdata(rdata[2]), .data_data_ok(dok[2]));

    typedef struct {
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] mm [int];          // reference memory, key = instance + word index
    int          prev_resp [3];
    int          dok_cnt   [3];
    logic [31:0] last_rd   [3];
    int          cyc = 0;
    int          n_checks  = 0;
    int          n_pass    = 0;
    exp_t        m_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 8;
    endfunction

    function automatic int qd_of(input int k);
        return (k == 1) ? 2 : 4;
    endfunction

    function automatic int key(input int k, input logic [31:0] a);
        return (k << 16) | int'(a[13:2]);
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Outstanding requests at cycle c are those whose response cycle is >= c.
    function automatic int count_ge(input int k, input int c);
        int n = 0;
        case (k)
            0:       foreach (q0[i]) if (q0[i].cyc >= c) n++;
            1:       foreach (q1[i]) if (q1[i].cyc >= c) n++;
            default: foreach (q2[i]) if (q2[i].cyc >= c) n++;
        endcase
        return n;
    endfunction

    task automatic qpush(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int k, output exp_t e);
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request, predict its acceptance cycle and response, and
    // hold it until accepted (bounded). Called just after a rising edge.
    task automatic issue(input int k, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        int          ec;
        int          t;
        int          kk;
        exp_t        e;
        logic [31:0] nv;
        ec = cyc;
        while (count_ge(k, ec) >= qd_of(k)) ec++;
        req[k] = 1'b1; wr[k] = w; strb[k] = s; addr[k] = a; wdata[k] = d;
        size[k] = 2'($urandom_range(0, 2));
        t = 0;
        forever begin
            @(negedge clk);
            if (aok[k] || t > 60) break;
            t++;
        end
        if (!aok[k]) begin
            n_checks++;
            $display("FAIL accept_timeout_k%0d: got no data_addr_ok, required acceptance in cycle %0d", k, ec);
        end else begin
            chk($sformatf("accept_cycle_k%0d", k), cyc, ec);
            e.cyc = (cyc + lat_of(k) > prev_resp[k] + 1) ? cyc + lat_of(k) : prev_resp[k] + 1;
            prev_resp[k] = e.cyc;
            kk = key(k, a);
            nv = mm.exists(kk) ? mm[kk] : 32'h0;
            if (w) begin
                for (int b = 0; b < 4; b++) if (s[b]) nv[8*b +: 8] = d[8*b +: 8];
                mm[kk] = nv;
                e.rd = 32'h0;
            end else begin
                e.rd = nv;
            end
            qpush(k, e);
        end
        @(posedge clk);
        #1;
        req[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int t = 0;
        while (qsize(k) != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (qsize(k) != 0) begin
            n_checks++;
            $display("FAIL drain_k%0d: got %0d responses missing, required 0", k, qsize(k));
        end
        tick(2);
    endtask

    task automatic preload(input int k);
        for (int i = 0; i < 16; i++) issue(k, 1'b1, 4'hF, 32'h100 + 32'(i * 4), $urandom);
        drain(k);
    endtask

    task automatic random_ops(input int k, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 15) * 4);
            a = a | (32'($urandom_range(0, 7)) << 14) | 32'($urandom_range(0, 3));
            issue(k, 1'(($urandom_range(0, 1))), 4'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
        drain(k);
    endtask

    // Monitor: every data_data_ok pulse must match the oldest prediction.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dok[k] === 1'b1) begin
                dok_cnt[k]++;
                last_rd[k] = rdata[k];
                if (qsize(k) == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_data_ok_k%0d: got a pulse in cycle %0d, required none", k, cyc);
                end else begin
                    qpop(k, m_e);
                    chk($sformatf("rdata_k%0d", k), rdata[k], m_e.rd);
                    chk($sformatf("resp_cycle_k%0d", k), cyc, m_e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [31:0] old0;
        logic [31:0] old1;
        int          dc;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd0; strb[k] = 4'h0;
            addr[k] = 32'h0; wdata[k] = 32'h0; prev_resp[k] = -1;
            dok_cnt[k] = 0; last_rd[k] = 32'h0;
        end
        tick(3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_data_ok_k%0d", k), {31'b0, dok[k]}, 32'h0);
            chk($sformatf("reset_rdata_k%0d", k), rdata[k], 32'h0);
            chk($sformatf("reset_addr_ok_k%0d", k), {31'b0, aok[k]}, 32'h0);
        end
        rst = 1'b0;
        tick(2);
        for (int k = 0; k < 3; k++)
            chk($sformatf("idle_addr_ok_k%0d", k), {31'b0, aok[k]}, 32'h0);

        // Store then load, back to back, LATENCY=2.
        issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        issue(0, 1'b0, 4'hF, 32'h10, 32'h0);
        drain(0);
        chk("store_then_load", last_rd[0], 32'hDEADBEEF);

        // Byte strobes, then a zero-strobe store that must change nothing.
        issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
        issue(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        issue(0, 1'b0, 4'hF, 32'h20, 32'h0);
        drain(0);
        chk("byte_strobes", last_rd[0], 32'h11BB33DD);
        issue(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF);
        issue(0, 1'b0, 4'hF, 32'h20, 32'h0);
        drain(0);
        chk("zero_strobe", last_rd[0], 32'h11BB33DD);

        // Aliasing: 0x4004 and 0x0004 are the same word when AW=12.
        v = $urandom;
        issue(0, 1'b1, 4'hF, 32'h0000_4004, v);
        issue(0, 1'b0, 4'hF, 32'h0000_0004, 32'h0);
        drain(0);
        chk("alias", last_rd[0], v);

        // Randomized traffic on every instance.
        for (int k = 0; k < 3; k++) begin
            preload(k);
            random_ops(k, 60);
        end

        // Six back-to-back loads of distinct words at LATENCY=1, depth 2.
        for (int i = 0; i < 6; i++) issue(1, 1'b0, 4'hF, 32'h100 + 32'(i * 4), 32'h0);
        drain(1);

        // Full queue at LATENCY=8: five requests held back to back; the
        // fifth waits until the cycle after the first response.
        for (int i = 0; i < 5; i++) issue(2, 1'(i % 2), 4'hF, 32'h100 + 32'(i * 4), $urandom);
        drain(2);

        // Reset mid-flight: two stores accepted, reset one cycle later.
        old0 = mm[key(2, 32'h100)];
        old1 = mm[key(2, 32'h104)];
        dc   = dok_cnt[2];
        issue(2, 1'b1, 4'hF, 32'h100, ~old0);
        issue(2, 1'b1, 4'hF, 32'h104, ~old1);
        rst = 1'b1;
        q2.delete();
        mm[key(2, 32'h100)] = old0;
        mm[key(2, 32'h104)] = old1;
        #1;
        chk("midreset_data_ok", {31'b0, dok[2]}, 32'h0);
        chk("midreset_rdata", rdata[2], 32'h0);
        tick(2);
        rst = 1'b0;
        tick(12);
        chk("no_pulse_after_reset", 32'(dok_cnt[2]), 32'(dc));
        issue(2, 1'b0, 4'hF, 32'h100, 32'h0);
        issue(2, 1'b0, 4'hF, 32'h104, 32'h0);
        drain(2);
        chk("reset_store_dropped", last_rd[2], old1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
